// File: rtl/interlaken_rx_latency_monitor.sv
// Receive-side latency probe on the Interlaken RX LBUS: recognises timestamped test
// messages, reports per-packet one-way latency and keeps per-run statistics.
module interlaken_rx_latency_monitor #(
    parameter int unsigned LAT_W  = 32,
    parameter int unsigned MAX_ID = 9,
    parameter logic [7:0]  MAGIC  = 8'hA5
) (
    input  logic               lbus_clk,
    input  logic               lbus_reset,
    input  logic [63:0]        time_now,
    input  logic               rx_ena,
    input  logic               rx_sop,
    input  logic               rx_eop,
    input  logic               rx_err,
    input  logic [127:0]       rx_data,
    input  logic               clear_stats,
    output logic               lat_valid,
    output logic [LAT_W-1:0]   lat_value,
    output logic [7:0]         lat_msg_id,
    output logic [15:0]        lat_seq,
    output logic [31:0]        pkt_count,
    output logic [LAT_W-1:0]   lat_min,
    output logic [LAT_W-1:0]   lat_max,
    output logic [47:0]        lat_sum,
    output logic [15:0]        err_count,
    output logic [15:0]        gap_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DROP    = 2'd2
    } state_t;

    localparam logic [LAT_W-1:0] LAT_ONES = {LAT_W{1'b1}};

    // Clamp a 64-bit raw latency into the LAT_W-bit result range.
    function automatic logic [LAT_W-1:0] sat_lat(input logic [63:0] raw);
        if (raw > 64'(LAT_ONES)) begin
            return LAT_ONES;
        end else begin
            return raw[LAT_W-1:0];
        end
    endfunction

    state_t              state_r, state_nx_s;
    logic [63:0]         lat_raw_r;
    logic [7:0]          msg_id_r;
    logic [15:0]         seq_r;

    logic                sop_s, eop_s, hdr_good_s, in_cap_s;
    logic                abandon_s, accept_s, discard_s;
    logic [63:0]         lat_raw_now_s, acc_raw_s;
    logic [7:0]          acc_id_s;
    logic [15:0]         acc_seq_s;
    logic [LAT_W-1:0]    acc_lat_s;
    logic [1:0]          err_inc_s;
    logic [16:0]         err_sum_s;
    logic [48:0]         sum_ext_s;
    logic                unused_s;

    logic                lat_valid_r;
    logic [LAT_W-1:0]    lat_value_r, lat_min_r, lat_max_r;
    logic [7:0]          lat_msg_id_r;
    logic [15:0]         lat_seq_r, err_count_r, gap_count_r, exp_seq_r;
    logic [31:0]         pkt_count_r;
    logic [47:0]         lat_sum_r;
    logic                first_seen_r;

    assign sop_s         = rx_ena & rx_sop;
    assign eop_s         = rx_ena & rx_eop;
    assign hdr_good_s    = (rx_data[127:120] == MAGIC) &&
                           (rx_data[119:112] >= 8'd1) &&
                           (rx_data[119:112] <= 8'(MAX_ID));
    assign lat_raw_now_s = time_now - rx_data[63:0];
    assign unused_s      = ^rx_data[95:64];

    // Packet classification: a same-beat SOP overrides whatever packet was in flight.
    always_comb begin
        abandon_s = 1'b0;
        in_cap_s  = 1'b0;
        acc_raw_s = lat_raw_r;
        acc_id_s  = msg_id_r;
        acc_seq_s = seq_r;
        case (state_r)
            ST_CAPTURE: abandon_s = sop_s;
            ST_IDLE:    abandon_s = 1'b0;
            ST_DROP:    abandon_s = 1'b0;
            default:    abandon_s = 1'b0;
        endcase
        if (sop_s) begin
            in_cap_s  = hdr_good_s;
            acc_raw_s = lat_raw_now_s;
            acc_id_s  = rx_data[119:112];
            acc_seq_s = rx_data[111:96];
        end else begin
            in_cap_s  = (state_r == ST_CAPTURE);
            acc_raw_s = lat_raw_r;
            acc_id_s  = msg_id_r;
            acc_seq_s = seq_r;
        end
    end

    assign accept_s  = eop_s & in_cap_s & ~rx_err;
    assign discard_s = eop_s & in_cap_s & rx_err;
    assign acc_lat_s = sat_lat(acc_raw_s);
    assign err_inc_s = {1'b0, abandon_s} + {1'b0, discard_s};
    assign err_sum_s = {1'b0, err_count_r} + {15'd0, err_inc_s};
    assign sum_ext_s = {1'b0, lat_sum_r} + 49'(acc_lat_s);

    // Next-state decode; EOP always returns to IDLE, idle beats hold state.
    always_comb begin
        state_nx_s = state_r;
        if (rx_ena) begin
            if (rx_eop) begin
                state_nx_s = ST_IDLE;
            end else if (rx_sop) begin
                state_nx_s = hdr_good_s ? ST_CAPTURE : ST_DROP;
            end else begin
                state_nx_s = state_r;
            end
        end else begin
            state_nx_s = state_r;
        end
    end

    // State register.
    always_ff @(posedge lbus_clk) begin
        if (lbus_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Header capture: raw latency is taken against the SOP-cycle time base.
    always_ff @(posedge lbus_clk) begin
        if (lbus_reset) begin
            lat_raw_r <= 64'd0;
            msg_id_r  <= 8'd0;
            seq_r     <= 16'd0;
        end else if (sop_s && hdr_good_s) begin
            lat_raw_r <= lat_raw_now_s;
            msg_id_r  <= rx_data[119:112];
            seq_r     <= rx_data[111:96];
        end
    end

    // Per-packet result registers; data holds until the next accept.
    always_ff @(posedge lbus_clk) begin
        if (lbus_reset) begin
            lat_valid_r  <= 1'b0;
            lat_value_r  <= '0;
            lat_msg_id_r <= 8'd0;
            lat_seq_r    <= 16'd0;
        end else begin
            lat_valid_r <= accept_s;
            if (accept_s) begin
                lat_value_r  <= acc_lat_s;
                lat_msg_id_r <= acc_id_s;
                lat_seq_r    <= acc_seq_s;
            end
        end
    end

    // Statistics; a clear in the same cycle as an accept drops that sample.
    always_ff @(posedge lbus_clk) begin
        if (lbus_reset || clear_stats) begin
            pkt_count_r  <= 32'd0;
            lat_min_r    <= LAT_ONES;
            lat_max_r    <= '0;
            lat_sum_r    <= 48'd0;
            err_count_r  <= 16'd0;
            gap_count_r  <= 16'd0;
            first_seen_r <= 1'b0;
            if (lbus_reset) begin
                exp_seq_r <= 16'd0;
            end
        end else begin
            err_count_r <= err_sum_s[16] ? 16'hFFFF : err_sum_s[15:0];
            if (accept_s) begin
                if (pkt_count_r != 32'hFFFF_FFFF) begin
                    pkt_count_r <= pkt_count_r + 32'd1;
                end
                if (acc_lat_s < lat_min_r) begin
                    lat_min_r <= acc_lat_s;
                end
                if (acc_lat_s > lat_max_r) begin
                    lat_max_r <= acc_lat_s;
                end
                lat_sum_r <= sum_ext_s[48] ? 48'hFFFF_FFFF_FFFF : sum_ext_s[47:0];
                if (first_seen_r && (acc_seq_s != exp_seq_r) && (gap_count_r != 16'hFFFF)) begin
                    gap_count_r <= gap_count_r + 16'd1;
                end
                exp_seq_r    <= acc_seq_s + 16'd1;
                first_seen_r <= 1'b1;
            end
        end
    end

    assign lat_valid  = lat_valid_r;
    assign lat_value  = lat_value_r;
    assign lat_msg_id = lat_msg_id_r;
    assign lat_seq    = lat_seq_r;
    assign pkt_count  = pkt_count_r;
    assign lat_min    = lat_min_r;
    assign lat_max    = lat_max_r;
    assign lat_sum    = lat_sum_r;
    assign err_count  = err_count_r;
    assign gap_count  = gap_count_r;

endmodule
